// File: rtl/gene_mem_pkg.sv
// Shared definitions for the SRAM record store: state encodings, SRAM data
// width, halfword-count derivation and the record layout used by writer and reader.
package gene_mem_pkg;

  localparam int SRAM_DATA_BITS = 16;

  // Record layout shared with the memory writer (gene, then timer, lowest halfword first)
  localparam int REC_WORD_BITS = 128;

  typedef enum logic [1:0] {
    T_IDLE,
    T_FETCH,
    T_PRESENT,
    T_DONE
  } top_state_t;

  typedef enum logic [1:0] {
    F_IDLE,
    F_SETUP,
    F_WAIT,
    F_CAPTURE
  } fetch_state_t;

  function automatic int hw_count(input int word_bits);
    return word_bits / SRAM_DATA_BITS;
  endfunction

  localparam int REC_HW = hw_count(REC_WORD_BITS);

endpackage

// File: rtl/sram_halfword_fetch.sv
// Single-halfword SRAM read engine: owns the SRAM pins and the READ_WAIT counter.
// A req accepted in idle or capture starts SETUP; ack marks the capture cycle.
module sram_halfword_fetch
  import gene_mem_pkg::*;
#(
  parameter int ADDR_BITS = 20,
  parameter int BASE_ADDR = 0,
  parameter int READ_WAIT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req,
  input  logic [ADDR_BITS-1:0] addr,
  output logic                 ack,
  output logic [15:0]          data,
  input  logic [15:0]          sram_dq,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_ub_n,
  output logic                 sram_lb_n,
  output logic                 sram_we_n
);

  localparam logic [2:0] WAIT_LOAD = (READ_WAIT > 0) ? 3'(READ_WAIT - 1) : 3'd0;

  fetch_state_t         state_r, state_s;
  logic [2:0]           wait_cnt_r, wait_cnt_s;
  logic                 sel_n_r;
  logic [ADDR_BITS-1:0] addr_r;

  // Next phase of the current halfword access
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = wait_cnt_r;
    case (state_r)
      F_IDLE: begin
        if (req) state_s = F_SETUP;
        else     state_s = F_IDLE;
      end
      F_SETUP: begin
        if (READ_WAIT == 0) begin
          state_s = F_CAPTURE;
        end else begin
          state_s    = F_WAIT;
          wait_cnt_s = WAIT_LOAD;
        end
      end
      F_WAIT: begin
        if (wait_cnt_r == 3'd0) state_s = F_CAPTURE;
        else                    wait_cnt_s = wait_cnt_r - 3'd1;
      end
      F_CAPTURE: begin
        if (req) state_s = F_SETUP;
        else     state_s = F_IDLE;
      end
      default: state_s = F_IDLE;
    endcase
  end

  // Phase register and registered pin drive; chip is selected for the whole access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= F_IDLE;
      wait_cnt_r <= 3'd0;
      sel_n_r    <= 1'b1;
      addr_r     <= ADDR_BITS'(BASE_ADDR);
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
      sel_n_r    <= (state_s == F_IDLE);
      if (req && (state_r == F_IDLE || state_r == F_CAPTURE)) addr_r <= addr;
    end
  end

  assign ack       = (state_r == F_CAPTURE);
  assign data      = sram_dq;
  assign sram_addr = addr_r;
  assign sram_ce_n = sel_n_r;
  assign sram_oe_n = sel_n_r;
  assign sram_ub_n = sel_n_r;
  assign sram_lb_n = sel_n_r;
  assign sram_we_n = 1'b1;

endmodule

// File: rtl/sram_record_reader.sv
// Reads rec_count wide records back from SRAM and presents them on a valid/ready port.
// Define READER_CHECKSUM_EN to build the running halfword checksum; otherwise checksum is 0.
module sram_record_reader
  import gene_mem_pkg::*;
#(
  parameter int WORD_BITS   = 128,
  parameter int ADDR_BITS   = 20,
  parameter int BASE_ADDR   = 0,
  parameter int READ_WAIT   = 1,
  parameter int MAX_RECORDS = 255
) (
  input  logic                 CLOCK_50,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           rec_count,
  output logic [WORD_BITS-1:0] rec_data,
  output logic                 rec_valid,
  input  logic                 rec_ready,
  output logic [7:0]           rec_index,
  output logic                 busy,
  output logic                 done,
  output logic                 addr_wrap,
  output logic [15:0]          checksum,
  output logic [ADDR_BITS-1:0] SRAM_ADDRESS_O,
  inout  wire  [15:0]          SRAM_DATA_IO,
  output logic                 SRAM_UB_N_O,
  output logic                 SRAM_LB_N_O,
  output logic                 SRAM_WE_N_O,
  output logic                 SRAM_CE_N_O,
  output logic                 SRAM_OE_N_O
);

  localparam int                   HW       = hw_count(WORD_BITS);
  localparam int                   KW       = (HW > 1) ? $clog2(HW) : 1;
  localparam logic [KW-1:0]        K_LAST   = KW'(HW - 1);
  localparam logic [KW-1:0]        K_ONE    = KW'(1'b1);
  localparam logic [ADDR_BITS-1:0] BASE     = ADDR_BITS'(BASE_ADDR);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1'b1);
  localparam logic [ADDR_BITS-1:0] ADDR_MAX = {ADDR_BITS{1'b1}};
  localparam logic [7:0]           MAX_CNT  = 8'(MAX_RECORDS);

  top_state_t           state_r, state_s;
  logic [7:0]           count_r, idx_r, count_in_s;
  logic [KW-1:0]        k_r;
  logic [ADDR_BITS-1:0] addr_r, fetch_addr_s;
  logic [WORD_BITS-1:0] data_r;
  logic                 valid_r, busy_r, done_r, wrap_r;
  logic                 req_s, ack_s, start_ok_s, accept_s, last_hw_s, last_rec_s;
  logic [15:0]          hw_data_s;

  // The reader never drives the shared data bus
  assign SRAM_DATA_IO = {16{1'bz}};

  sram_halfword_fetch #(
    .ADDR_BITS (ADDR_BITS),
    .BASE_ADDR (BASE_ADDR),
    .READ_WAIT (READ_WAIT)
  ) u_fetch (
    .clk       (CLOCK_50),
    .rst_n     (rst),
    .req       (req_s),
    .addr      (fetch_addr_s),
    .ack       (ack_s),
    .data      (hw_data_s),
    .sram_dq   (SRAM_DATA_IO),
    .sram_addr (SRAM_ADDRESS_O),
    .sram_ce_n (SRAM_CE_N_O),
    .sram_oe_n (SRAM_OE_N_O),
    .sram_ub_n (SRAM_UB_N_O),
    .sram_lb_n (SRAM_LB_N_O),
    .sram_we_n (SRAM_WE_N_O)
  );

  // Handshake qualifiers and the address handed to the fetch engine with each req
  always_comb begin
    count_in_s = (rec_count > MAX_CNT) ? MAX_CNT : rec_count;
    start_ok_s = (state_r == T_IDLE) && start;
    accept_s   = (state_r == T_PRESENT) && rec_ready;
    last_hw_s  = ack_s && (k_r == K_LAST);
    last_rec_s = (idx_r == count_r - 8'd1);
    if (state_r == T_IDLE) fetch_addr_s = BASE;
    else if (ack_s)        fetch_addr_s = addr_r + ADDR_ONE;
    else                   fetch_addr_s = addr_r;
  end

  // Record sequencing; req stays high so the next SETUP follows a CAPTURE back to back
  always_comb begin
    state_s = state_r;
    req_s   = 1'b0;
    case (state_r)
      T_IDLE: begin
        if (start && (count_in_s != 8'd0)) begin
          state_s = T_FETCH;
          req_s   = 1'b1;
        end else if (start) begin
          state_s = T_DONE;
        end else begin
          state_s = T_IDLE;
        end
      end
      T_FETCH: begin
        if (last_hw_s) begin
          state_s = T_PRESENT;
        end else begin
          state_s = T_FETCH;
          req_s   = 1'b1;
        end
      end
      T_PRESENT: begin
        if (rec_ready && last_rec_s) begin
          state_s = T_DONE;
        end else if (rec_ready) begin
          state_s = T_FETCH;
          req_s   = 1'b1;
        end else begin
          state_s = T_PRESENT;
        end
      end
      T_DONE:  state_s = T_IDLE;
      default: state_s = T_IDLE;
    endcase
  end

  // State, counters, record assembly and registered status outputs
  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      state_r <= T_IDLE;
      count_r <= 8'd0;
      idx_r   <= 8'd0;
      k_r     <= {KW{1'b0}};
      addr_r  <= BASE;
      data_r  <= {WORD_BITS{1'b0}};
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      wrap_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      if (start_ok_s) begin
        count_r <= count_in_s;
        idx_r   <= 8'd0;
        k_r     <= {KW{1'b0}};
        addr_r  <= BASE;
        wrap_r  <= 1'b0;
      end else if (ack_s) begin
        data_r[16*int'(k_r) +: 16] <= hw_data_s;
        k_r    <= last_hw_s ? {KW{1'b0}} : k_r + K_ONE;
        addr_r <= addr_r + ADDR_ONE;
        if (addr_r == ADDR_MAX) wrap_r <= 1'b1;
      end else if (accept_s && !last_rec_s) begin
        idx_r <= idx_r + 8'd1;
      end
      valid_r <= (state_s == T_PRESENT);
      busy_r  <= (state_s != T_IDLE);
      done_r  <= (state_r == T_DONE);
    end
  end

`ifdef READER_CHECKSUM_EN
  logic [15:0] sum_r;

  // Running modulo-2^16 sum of every captured halfword
  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst)            sum_r <= 16'h0000;
    else if (start_ok_s) sum_r <= 16'h0000;
    else if (ack_s)      sum_r <= sum_r + hw_data_s;
  end

  assign checksum = sum_r;
`else
  assign checksum = 16'h0000;
`endif

  assign rec_data  = data_r;
  assign rec_valid = valid_r;
  assign rec_index = idx_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign addr_wrap = wrap_r;

endmodule
